// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage (master)
// and the instruction memory (slave).
interface fetch_stage_if #(
    parameter int DATA_LENGTH = 32
);
    logic                   imem_req;
    logic [DATA_LENGTH-1:0] imem_addr;
    logic                   imem_ack;
    logic [DATA_LENGTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID register: owns the PC, talks req/ack to imem,
// applies decode redirects (branch, J, JR) with flush and honours hazard stall.
module fetch_stage #(
    parameter int                     DATA_LENGTH = 32,
    parameter logic [DATA_LENGTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic [1:0]             pc_src_sel,
    input  logic [DATA_LENGTH-1:0] extend_imm,
    input  logic [DATA_LENGTH-1:0] reg_target,
    fetch_stage_if.master          imem,
    output logic [DATA_LENGTH-1:0] inst_out,
    output logic                   inst_en,
    output logic [DATA_LENGTH-1:0] pc_plus4_out,
    output logic                   fetch_busy
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP, S_HOLD} state_t;

    state_t                 state, state_d;
    logic [DATA_LENGTH-1:0] addr_q, addr_d;
    logic [DATA_LENGTH-1:0] pc, pc_d;
    logic [DATA_LENGTH-1:0] inst_d, pc4_d;
    logic                   en_d;
    logic [DATA_LENGTH-1:0] hold_inst, hold_inst_d;
    logic [DATA_LENGTH-1:0] hold_pc4, hold_pc4_d;

    logic                          redirect;
    logic signed [DATA_LENGTH-1:0] branch_off;
    logic [DATA_LENGTH-1:0]        target;
    logic [DATA_LENGTH-1:0]        addr_inc;

    assign redirect   = inst_en & ~stall & (pc_src_sel != 2'b00);
    assign branch_off = $signed(extend_imm) <<< 2;
    assign addr_inc   = addr_q + DATA_LENGTH'(4);

    // Redirect targets are formed from the instruction currently held in IF/ID.
    always_comb begin
        unique case (pc_src_sel)
            2'b01:   target = pc_plus4_out + $unsigned(branch_off);
            2'b10:   target = {pc_plus4_out[DATA_LENGTH-1 -: 4], inst_out[25:0], 2'b00};
            2'b11:   target = reg_target;
            default: target = pc_plus4_out;
        endcase
    end

    assign imem.imem_req  = (state == S_REQ) || (state == S_DROP);
    assign imem.imem_addr = addr_q;
    assign fetch_busy     = (state == S_DROP) || (state == S_HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d     = state;
        addr_d      = addr_q;
        pc_d        = pc;
        inst_d      = inst_out;
        en_d        = inst_en;
        pc4_d       = pc_plus4_out;
        hold_inst_d = hold_inst;
        hold_pc4_d  = hold_pc4;

        // No delay slot: whatever sits behind a taken redirect is squashed.
        if (redirect) begin
            inst_d = '0;
            en_d   = 1'b0;
        end

        unique case (state)
            S_IDLE: begin
                state_d = S_REQ;
                addr_d  = pc;
            end
            S_REQ: begin
                if (imem.imem_ack) begin
                    if (redirect) begin
                        addr_d = target;
                        pc_d   = target;
                    end else if (!stall) begin
                        inst_d = imem.imem_rdata;
                        pc4_d  = addr_inc;
                        en_d   = 1'b1;
                        addr_d = addr_inc;
                        pc_d   = addr_inc;
                    end else begin
                        hold_inst_d = imem.imem_rdata;
                        hold_pc4_d  = addr_inc;
                        pc_d        = addr_inc;
                        state_d     = S_HOLD;
                    end
                end else if (redirect) begin
                    pc_d    = target;
                    state_d = S_DROP;
                end else if (!stall) begin
                    en_d = 1'b0;
                end
            end
            S_DROP: begin
                // Keep the stale request alive until memory answers, then discard it.
                if (redirect) pc_d = target;
                if (!stall) begin
                    inst_d = '0;
                    en_d   = 1'b0;
                end
                if (imem.imem_ack) begin
                    addr_d  = redirect ? target : pc;
                    state_d = S_REQ;
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    state_d = S_REQ;
                    if (redirect) begin
                        addr_d = target;
                        pc_d   = target;
                    end else begin
                        inst_d = hold_inst;
                        pc4_d  = hold_pc4;
                        en_d   = 1'b1;
                        addr_d = pc;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= RESET_PC;
            pc           <= RESET_PC;
            inst_out     <= '0;
            inst_en      <= 1'b0;
            pc_plus4_out <= '0;
            hold_inst    <= '0;
            hold_pc4     <= '0;
        end else begin
            addr_q       <= addr_d;
            pc           <= pc_d;
            inst_out     <= inst_d;
            inst_en      <= en_d;
            pc_plus4_out <= pc4_d;
            hold_inst    <= hold_inst_d;
            hold_pc4     <= hold_pc4_d;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus pushes expected IF/ID words into a
// scoreboard queue that a negedge monitor pops on every new IF/ID delivery.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  pc_src_sel = 2'b00;
    logic [31:0] extend_imm = '0;
    logic [31:0] reg_target = '0;
    logic        ack = 1'b0;
    logic [31:0] inst_out;
    logic        inst_en;
    logic [31:0] pc_plus4_out;
    logic        fetch_busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
    } exp_t;
    exp_t sb_q[$];

    fetch_stage_if #(.DATA_LENGTH(32)) bus ();

    // 0x14 holds a J to 0x100; every other word encodes its own address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h14) ? 32'h0800_0040 : (32'h8C00_0000 | a);
    endfunction

    assign bus.imem_ack   = ack;
    assign bus.imem_rdata = mem_word(bus.imem_addr);

    fetch_stage #(.DATA_LENGTH(32), .RESET_PC(32'h0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .pc_src_sel   (pc_src_sel),
        .extend_imm   (extend_imm),
        .reg_target   (reg_target),
        .imem         (bus.master),
        .inst_out     (inst_out),
        .inst_en      (inst_en),
        .pc_plus4_out (pc_plus4_out),
        .fetch_busy   (fetch_busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] a);
        sb_q.push_back('{inst: mem_word(a), pc4: a + 32'd4});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " req"},      32'(bus.imem_req), 32'd0);
        chk({tag, " addr"},     bus.imem_addr,     32'h0);
        chk({tag, " inst_en"},  32'(inst_en),      32'd0);
        chk({tag, " inst_out"}, inst_out,          32'h0);
        chk({tag, " pc4"},      pc_plus4_out,      32'h0);
        chk({tag, " busy"},     32'(fetch_busy),   32'd0);
    endtask

    // Monitor: a new delivery is inst_en high with a PC+4 differing from a held one.
    initial begin
        logic        prev_en;
        logic [31:0] prev_pc4;
        exp_t        e;
        prev_en  = 1'b0;
        prev_pc4 = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_en = 1'b0;
            end else begin
                if (inst_en && !(prev_en && prev_pc4 == pc_plus4_out)) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL ifid_unexpected: got inst %h pc4 %h expected no delivery",
                                 inst_out, pc_plus4_out);
                    end else begin
                        e = sb_q.pop_front();
                        if (inst_out !== e.inst || pc_plus4_out !== e.pc4) begin
                            errors++;
                            $display("FAIL ifid_word: got inst %h pc4 %h expected inst %h pc4 %h",
                                     inst_out, pc_plus4_out, e.inst, e.pc4);
                        end
                    end
                end
                prev_en  = inst_en;
                prev_pc4 = pc_plus4_out;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        step();
        step();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        ack   = 1'b1;
        step();
        chk("first req",  32'(bus.imem_req), 32'd1);
        chk("first addr", bus.imem_addr,     32'h0);

        // Zero-wait sequential fetch: one word per cycle
        for (int k = 1; k <= 5; k++) begin
            push(32'(4 * (k - 1)));
            step();
            chk("seq addr", bus.imem_addr, 32'(4 * k));
            chk("seq en",   32'(inst_en),  32'd1);
        end

        // Taken branch back by two words from the 0x10 instruction
        pc_src_sel = 2'b01;
        extend_imm = 32'hFFFF_FFFE;
        step();
        pc_src_sel = 2'b00;
        chk("br addr",  bus.imem_addr, 32'h0C);
        chk("br flush", 32'(inst_en),  32'd0);
        chk("br inst",  inst_out,      32'h0);
        push(32'h0C);
        step();
        push(32'h10);
        step();
        push(32'h14);
        step();
        chk("j in ifid", inst_out,      32'h0800_0040);
        chk("j addr",    bus.imem_addr, 32'h18);

        // J while the request is waiting on memory
        ack        = 1'b0;
        pc_src_sel = 2'b10;
        step();
        pc_src_sel = 2'b00;
        chk("drop busy", 32'(fetch_busy),   32'd1);
        chk("drop req",  32'(bus.imem_req), 32'd1);
        chk("drop addr", bus.imem_addr,     32'h18);
        chk("drop en",   32'(inst_en),      32'd0);
        step();
        chk("drop addr2", bus.imem_addr, 32'h18);
        step();
        chk("drop addr3", bus.imem_addr, 32'h18);
        ack = 1'b1;
        step();
        chk("j target", bus.imem_addr,   32'h100);
        chk("j busy",   32'(fetch_busy), 32'd0);
        push(32'h100);
        step();

        // Stall for four cycles with the ack arriving on the first
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("hold req",  32'(bus.imem_req), 32'd0);
            chk("hold busy", 32'(fetch_busy),   32'd1);
            chk("hold pc4",  pc_plus4_out,      32'h104);
            chk("hold en",   32'(inst_en),      32'd1);
        end
        stall = 1'b0;
        push(32'h104);
        step();
        chk("resume addr", bus.imem_addr,   32'h108);
        chk("resume req",  32'(bus.imem_req), 32'd1);
        push(32'h108);
        step();

        // JR requested under stall takes effect only once the stall clears
        stall      = 1'b1;
        pc_src_sel = 2'b11;
        reg_target = 32'h2000;
        step();
        chk("jr stall pc4", pc_plus4_out, 32'h10C);
        step();
        chk("jr stall en", 32'(inst_en), 32'd1);
        stall = 1'b0;
        step();
        pc_src_sel = 2'b00;
        chk("jr addr", bus.imem_addr, 32'h2000);
        chk("jr en",   32'(inst_en),  32'd0);
        push(32'h2000);
        step();
        chk("jr next", bus.imem_addr, 32'h2004);

        // Asynchronous reset while a dropped request is outstanding
        ack        = 1'b0;
        pc_src_sel = 2'b11;
        reg_target = 32'h3000;
        step();
        pc_src_sel = 2'b00;
        chk("pre-rst busy", 32'(fetch_busy), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async rst");
        step();
        rst_n = 1'b1;
        ack   = 1'b1;
        step();
        chk("restart addr", bus.imem_addr, 32'h0);
        push(32'h0);
        step();
        chk("restart addr2", bus.imem_addr, 32'h4);
        push(32'h4);
        step();
        #10;
        chk("sb drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
